// File: rtl/controller_pio_pkg.sv
// Shared constants for the controller PIO: register word offsets, capture-edge
// selections and interrupt source selections.
package controller_pio_pkg;

  typedef enum logic [2:0] {
    REG_DATA   = 3'd0,
    REG_DIR    = 3'd1,
    REG_MASK   = 3'd2,
    REG_EDGE   = 3'd3,
    REG_OUTSET = 3'd4,
    REG_OUTCLR = 3'd5,
    REG_RSVD6  = 3'd6,
    REG_RSVD7  = 3'd7
  } reg_addr_e;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  localparam int IRQ_EDGE  = 0;
  localparam int IRQ_LEVEL = 1;

endpackage

// File: rtl/controller_pio_gen2_sync_edge.sv
// Input conditioning for the PIO: two-flop synchroniser followed by a history
// stage, producing the synced level and a one-cycle edge pulse per bit.
module pio_sync_edge
  import controller_pio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] pulse
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] level_q;
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta    <= '0;
      level_q <= '0;
      prev    <= '0;
    end else begin
      meta    <= pins;
      level_q <= meta;
      prev    <= level_q;
    end
  end

  // Edge polarity is fixed at elaboration; the pulse is combinational so the
  // capture register sets on the edge right after the synced level changes.
  always_comb begin
    pulse = level_q & ~prev;
    if (EDGE_TYPE == EDGE_FALLING) begin
      pulse = ~level_q & prev;
    end else if (EDGE_TYPE == EDGE_ANY) begin
      pulse = level_q ^ prev;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/controller_pio_gen2.sv
// Avalon-MM PIO with per-bit direction, synchronised input sampling, edge
// capture and a maskable registered interrupt.
module controller_pio_gen2
  import controller_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               EDGE_TYPE   = EDGE_RISING,
  parameter int               IRQ_TYPE    = IRQ_EDGE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_en,
  output logic             irq
);

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] edge_q;
  logic [31:0]      rdata_q;
  logic             irq_q;

  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] rd_val;
  logic [31:0]      rd_word;
  logic [WIDTH-1:0] irq_src;
  logic             wr_en;
  logic             rd_en;
  reg_addr_e        reg_sel;

  assign wr_en   = chipselect & ~write_n;
  assign rd_en   = chipselect & ~read_n;
  assign reg_sel = reg_addr_e'(address);
  assign wd      = writedata[WIDTH-1:0];

  if (WIDTH < 32) begin : g_wd_upper
    logic unused_wd_upper;
    assign unused_wd_upper = ^writedata[31:WIDTH];
  end

  pio_sync_edge #(
    .WIDTH    (WIDTH),
    .EDGE_TYPE(EDGE_TYPE)
  ) u_sync_edge (
    .clk    (clk),
    .reset_n(reset_n),
    .pins   (in_port),
    .level  (in_sync),
    .pulse  (edge_pulse)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q  <= RESET_VALUE;
      dir_q  <= '0;
      mask_q <= '0;
    end else if (wr_en) begin
      case (reg_sel)
        REG_DATA:   out_q  <= wd;
        REG_DIR:    dir_q  <= wd;
        REG_MASK:   mask_q <= wd;
        REG_OUTSET: out_q  <= out_q | wd;
        REG_OUTCLR: out_q  <= out_q & ~wd;
        default:    ;
      endcase
    end
  end

  // A new edge in the same cycle as a write-1-to-clear keeps the bit set.
  assign edge_clr = (wr_en && reg_sel == REG_EDGE) ? wd : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_q <= '0;
    end else begin
      edge_q <= (edge_q & ~edge_clr) | edge_pulse;
    end
  end

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      REG_DATA: rd_val = (in_sync & ~dir_q) | (out_q & dir_q);
      REG_DIR:  rd_val = dir_q;
      REG_MASK: rd_val = mask_q;
      REG_EDGE: rd_val = edge_q;
      default:  rd_val = '0;
    endcase
    rd_word              = '0;
    rd_word[WIDTH-1:0]   = rd_val;
  end

  // Read data is sampled from pre-write register state, so a simultaneous
  // write to the same offset is not visible until the next read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      rdata_q <= rd_word;
    end
  end

  assign irq_src = (IRQ_TYPE == IRQ_LEVEL) ? (in_sync & mask_q) : (edge_q & mask_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |irq_src;
    end
  end

  assign out_port = out_q;
  assign out_en   = dir_q;
  assign readdata = rdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_controller_pio_gen2.sv
// Bench for controller_pio_gen2: a rising-edge/edge-irq instance and an
// any-edge/level-irq instance share one bus, checked against a history model.
module tb_controller_pio_gen2;
  import controller_pio_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;

  logic [31:0] readdata0, readdata1;
  logic [7:0]  out_port0, out_port1, out_en0, out_en1;
  logic        irq0, irq1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  controller_pio_gen2 #(
    .WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(EDGE_RISING), .IRQ_TYPE(IRQ_EDGE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata0),
    .in_port(in_port), .out_port(out_port0), .out_en(out_en0), .irq(irq0)
  );

  controller_pio_gen2 #(
    .WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(EDGE_ANY), .IRQ_TYPE(IRQ_LEVEL)
  ) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata1),
    .in_port(in_port), .out_port(out_port1), .out_en(out_en1), .irq(irq1)
  );

  // Reference model: register contents per instance plus the list of in_port
  // values seen at recent clock edges (newest last).
  int          edge_cfg[2] = '{EDGE_RISING, EDGE_ANY};
  int          irq_cfg[2]  = '{IRQ_EDGE, IRQ_LEVEL};
  logic [7:0]  m_out[2], m_dir[2], m_mask[2], m_edge[2];
  logic [31:0] m_rd[2];
  logic        m_irq[2];
  logic [7:0]  samples[$];
  logic [7:0]  cur_in;

  function automatic logic [7:0] seen(input int age);
    if (age < samples.size()) return samples[samples.size() - 1 - age];
    return 8'h00;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_out[d] = 8'hA5; m_dir[d] = 8'h00; m_mask[d] = 8'h00;
      m_edge[d] = 8'h00; m_rd[d] = 32'h0; m_irq[d] = 1'b0;
    end
    samples.delete();
  endtask

  task automatic model_step();
    logic [7:0] lvl, prv, ev, v, clr, wd8, nedge;
    logic wr, rd, nirq;
    wr  = chipselect && !write_n;
    rd  = chipselect && !read_n;
    wd8 = writedata[7:0];
    // Visible level is the input from two edges ago; previous is three ago.
    lvl = seen(1);
    prv = seen(2);
    for (int d = 0; d < 2; d++) begin
      if (edge_cfg[d] == EDGE_RISING)       ev = lvl & ~prv;
      else if (edge_cfg[d] == EDGE_FALLING) ev = ~lvl & prv;
      else                                  ev = lvl ^ prv;
      if (rd) begin
        case (address)
          3'd0:    v = (lvl & ~m_dir[d]) | (m_out[d] & m_dir[d]);
          3'd1:    v = m_dir[d];
          3'd2:    v = m_mask[d];
          3'd3:    v = m_edge[d];
          default: v = 8'h00;
        endcase
        m_rd[d] = {24'h0, v};
      end
      nirq  = (irq_cfg[d] == IRQ_LEVEL) ? |(lvl & m_mask[d]) : |(m_edge[d] & m_mask[d]);
      clr   = (wr && address == 3'd3) ? wd8 : 8'h00;
      nedge = (m_edge[d] & ~clr) | ev;
      if (wr) begin
        case (address)
          3'd0: m_out[d]  = wd8;
          3'd1: m_dir[d]  = wd8;
          3'd2: m_mask[d] = wd8;
          3'd4: m_out[d]  = m_out[d] | wd8;
          3'd5: m_out[d]  = m_out[d] & ~wd8;
          default: ;
        endcase
      end
      m_edge[d] = nedge;
      m_irq[d]  = nirq;
    end
    samples.push_back(in_port);
    if (samples.size() > 3) void'(samples.pop_front());
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    checkOutput("out_port0", {24'h0, out_port0}, {24'h0, m_out[0]});
    checkOutput("out_en0",   {24'h0, out_en0},   {24'h0, m_dir[0]});
    checkOutput("irq0",      {31'h0, irq0},      {31'h0, m_irq[0]});
    checkOutput("readdata0", readdata0,          m_rd[0]);
    checkOutput("out_port1", {24'h0, out_port1}, {24'h0, m_out[1]});
    checkOutput("out_en1",   {24'h0, out_en1},   {24'h0, m_dir[1]});
    checkOutput("irq1",      {31'h0, irq1},      {31'h0, m_irq[1]});
    checkOutput("readdata1", readdata1,          m_rd[1]);
  endtask

  // Called at a falling edge: drive, clock once, update model, check.
  task automatic applyStimulus(input logic cs, input logic wn, input logic rn,
                               input logic [2:0] addr, input logic [31:0] wd);
    chipselect = cs; write_n = wn; read_n = rn; address = addr;
    writedata = wd; in_port = cur_in;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b1, 3'd0, 32'h0);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    applyStimulus(1'b1, 1'b0, 1'b1, a, d);
  endtask

  task automatic rd_reg(input logic [2:0] a);
    applyStimulus(1'b1, 1'b1, 1'b0, a, 32'h0);
  endtask

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
    address = 3'd0; writedata = 32'h0; cur_in = 8'h5A; in_port = cur_in;
    model_reset();
    repeat (3) @(negedge clk);
    checkOutput("rst_out_port", {24'h0, out_port0}, 32'h0000_00A5);
    checkOutput("rst_out_en",   {24'h0, out_en0},   32'h0);
    checkOutput("rst_irq",      {31'h0, irq0},      32'h0);
    checkOutput("rst_readdata", readdata0,          32'h0);
    reset_n = 1'b1;

    // Data read with all bits as inputs returns the synced pins.
    idle(3);
    rd_reg(3'd0);
    checkOutput("t1_data_in", readdata0, 32'h0000_005A);
    rd_reg(3'd2);
    checkOutput("t1_mask", readdata0, 32'h0);

    // Direction mix: upper nibble from out register, lower from pins.
    wr_reg(3'd1, 32'hFFFF_FFF0);
    wr_reg(3'd0, 32'h0000_003C);
    wr_reg(3'd4, 32'h0000_0001);
    wr_reg(3'd5, 32'h0000_0004);
    checkOutput("t2_out_port", {24'h0, out_port0}, 32'h39);
    checkOutput("t2_out_en",   {24'h0, out_en0},   32'hF0);
    cur_in = 8'h0F;
    idle(3);
    rd_reg(3'd0);
    checkOutput("t2_data_mix", readdata0, 32'h3F);

    // Rising edge on bit1 with mask: capture, irq, then clear.
    wr_reg(3'd2, 32'h02);
    cur_in = 8'h0D; idle(4);
    wr_reg(3'd3, 32'hFF);
    cur_in = 8'h0F; idle(3);
    checkOutput("t3_irq_not_yet", {31'h0, irq0}, 32'h0);
    rd_reg(3'd3);
    checkOutput("t3_edge", readdata0, 32'h02);
    checkOutput("t3_irq_set", {31'h0, irq0}, 32'h1);
    wr_reg(3'd3, 32'h02);
    checkOutput("t3_irq_hold", {31'h0, irq0}, 32'h1);
    idle(1);
    checkOutput("t3_irq_clr", {31'h0, irq0}, 32'h0);

    // Clear coinciding with a new rising edge: set wins.
    cur_in = 8'h0D; idle(4);
    cur_in = 8'h0F; idle(4);
    cur_in = 8'h0D; idle(4);
    cur_in = 8'h0F; idle(2);
    wr_reg(3'd3, 32'h02);
    idle(1);
    rd_reg(3'd3);
    checkOutput("t4_edge_kept", readdata0, 32'h02);
    checkOutput("t4_irq_kept", {31'h0, irq0}, 32'h1);

    // Any-edge instance: a short pulse on bit3 sets the capture once.
    cur_in = 8'h07; idle(4);
    wr_reg(3'd3, 32'hFF);
    cur_in = 8'h0F; idle(1);
    cur_in = 8'h07; idle(5);
    rd_reg(3'd3);
    checkOutput("t5_any_edge", readdata1, 32'h08);

    // Randomised bus traffic and pin activity.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) cur_in = 8'($urandom);
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom),
                    3'($urandom_range(0, 7)), $urandom);
    end

    // Asynchronous reset while irq is high and out is all ones.
    wr_reg(3'd1, 32'hFF);
    wr_reg(3'd0, 32'hFF);
    wr_reg(3'd2, 32'hFF);
    cur_in = 8'h00; idle(4);
    wr_reg(3'd3, 32'hFF);
    cur_in = 8'hFF; idle(5);
    checkOutput("t6_pre_irq", {31'h0, irq0}, 32'h1);
    checkOutput("t6_pre_out", {24'h0, out_port0}, 32'hFF);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("t6_async_out",  {24'h0, out_port0}, 32'hA5);
    checkOutput("t6_async_en",   {24'h0, out_en0},   32'h0);
    checkOutput("t6_async_irq",  {31'h0, irq0},      32'h0);
    checkOutput("t6_async_rd",   readdata0,          32'h0);
    checkOutput("t6_async_irq1", {31'h0, irq1},      32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    idle(3);
    rd_reg(3'd0);
    checkOutput("t6_rd_after", readdata0, 32'h0000_00FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
